// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU function encoding and arbiter FSM states.
// Codes 6 and 7 are deliberately left unassigned and treated as illegal functions.
package alu_pkg;

  localparam int ALU_FUNC_W = 3;

  typedef enum logic [ALU_FUNC_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_func_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } alu_arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the arbiter (slave) and its environment (master).
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 4
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_W-1:0]     req_operand_a;
  logic [NUM_REQ*DATA_W-1:0]     req_operand_b;
  logic [NUM_REQ*ALU_FUNC_W-1:0] req_alu_func;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_W-1:0]             rsp_result;
  logic                          rsp_zero_flag;
  logic                          rsp_positive_flag;
  logic                          rsp_carry_flag;
  logic                          rsp_signed_overflow;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_alu_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero_flag,
           rsp_positive_flag, rsp_carry_flag, rsp_signed_overflow
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_alu_func, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero_flag,
           rsp_positive_flag, rsp_carry_flag, rsp_signed_overflow
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR/INV with zero, positive, carry and signed-overflow flags.
// SUB carry is the carry-out of a + ~b + 1, i.e. 1 means "no borrow".
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_func_e         func_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              positive_o,
  output logic              carry_o,
  output logic              overflow_o
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Operation select and flag generation
  always_comb begin
    sum_s      = {1'b0, a_i} + {1'b0, b_i};
    diff_s     = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (func_i)
      ALU_ADD: begin
        result_o   = sum_s[DATA_W-1:0];
        carry_o    = sum_s[DATA_W];
        overflow_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                     (sum_s[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        result_o   = diff_s[DATA_W-1:0];
        carry_o    = diff_s[DATA_W];
        overflow_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                     (diff_s[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_INV: result_o = ~a_i;
      default: result_o = '0;
    endcase
    zero_o     = (result_o == '0);
    positive_o = ~result_o[DATA_W-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one ALU with a single registered response slot.
// Define ALU_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  alu_arb_state_e       state_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [DATA_W-1:0]    rsp_result_q;
  logic                 rsp_zero_q;
  logic                 rsp_positive_q;
  logic                 rsp_carry_q;
  logic                 rsp_overflow_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
  logic [ID_W-1:0]      last_grant_q;
`endif

  logic [ID_W-1:0]       grant_idx_s;
  logic                  grant_found_s;
  logic                  can_grant_s;
  logic                  accept_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [DATA_W-1:0]     op_a_s;
  logic [DATA_W-1:0]     op_b_s;
  logic [ALU_FUNC_W-1:0] func_s;

  logic [DATA_W-1:0]     result_d;
  logic                  zero_d;
  logic                  positive_d;
  logic                  carry_d;
  logic                  overflow_d;

  // Grant selection: loops run farthest-to-nearest so the nearest valid requester wins
  always_comb begin
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant_idx_s   = ID_W'(k);
        grant_found_s = 1'b1;
      end
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        grant_idx_s   = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
        grant_found_s = 1'b1;
      end
    end
`endif
    can_grant_s = (state_q == IDLE) || bus.rsp_ready;
    accept_s    = grant_found_s && can_grant_s;
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Operand mux from the granted requester into the single ALU
  always_comb begin
    op_a_s = bus.req_operand_a[int'(grant_idx_s) * DATA_W +: DATA_W];
    op_b_s = bus.req_operand_b[int'(grant_idx_s) * DATA_W +: DATA_W];
    func_s = bus.req_alu_func[int'(grant_idx_s) * ALU_FUNC_W +: ALU_FUNC_W];
  end

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i        (op_a_s),
    .b_i        (op_b_s),
    .func_i     (alu_func_e'(func_s)),
    .result_o   (result_d),
    .zero_o     (zero_d),
    .positive_o (positive_d),
    .carry_o    (carry_d),
    .overflow_o (overflow_d)
  );

  // Response-slot FSM; payload only changes on accept, so it is stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_positive_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      last_grant_q   <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      if (accept_s) begin
        rsp_id_q       <= grant_idx_s;
        rsp_result_q   <= result_d;
        rsp_zero_q     <= zero_d;
        rsp_positive_q <= positive_d;
        rsp_carry_q    <= carry_d;
        rsp_overflow_q <= overflow_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
        last_grant_q   <= grant_idx_s;
`endif
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q <= HOLD;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (bus.rsp_ready && !accept_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready           = req_ready_s;
  assign bus.rsp_valid           = (state_q == HOLD);
  assign bus.rsp_id              = rsp_id_q;
  assign bus.rsp_result          = rsp_result_q;
  assign bus.rsp_zero_flag       = rsp_zero_q;
  assign bus.rsp_positive_flag   = rsp_positive_q;
  assign bus.rsp_carry_flag      = rsp_carry_q;
  assign bus.rsp_signed_overflow = rsp_overflow_q;

endmodule
